// File: rtl/bcd_result_display_if.sv
// Result bus between the BCD divider and the result display stage.
//   end_division : one-cycle capture strobe from the divider
//   quotient     : 4-digit BCD quotient, digit 3 in [15:12]
//   remainder    : 4-digit BCD remainder, same layout
//   clear        : synchronous request to drop the held result
//   an           : digit enables, active-low one-hot, an[0] = least significant digit
//   seg          : segments {g,f,e,d,c,b,a}, active-low
//   page         : 0 = quotient page shown, 1 = remainder page shown
//   valid        : 1 = a captured result is held
// master = divider/host side, slave = display stage.
interface bcd_result_display_if;
  logic        end_division;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        clear;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        page;
  logic        valid;

  modport master (
    output end_division, quotient, remainder, clear,
    input  an, seg, page, valid
  );

  modport slave (
    input  end_division, quotient, remainder, clear,
    output an, seg, page, valid
  );
endinterface

// File: rtl/bcd_result_display.sv
// Output stage for the 4-digit BCD divider. Captures quotient and remainder
// on end_division and drives a time-multiplexed 4-digit common-anode
// seven-segment display, alternating between a quotient page and a remainder
// page. Provides leading-zero blanking, an "E" for invalid nibbles and a dash
// pattern while no result is held.
// Ports:
//   clk : system clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : result bus (slave side), see bcd_result_display_if
// Parameters:
//   SCAN_DIV    : clock cycles each digit stays selected (>= 1)
//   PAGE_CYCLES : clock cycles each page is shown before toggling (>= 2)
module bcd_result_display #(
  parameter int SCAN_DIV    = 4,
  parameter int PAGE_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_result_display_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TW = $clog2(PAGE_CYCLES);
  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [TW-1:0] PAGE_LAST = TW'(PAGE_CYCLES - 1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  logic [15:0]   q_held;
  logic [15:0]   r_held;
  logic          valid_q;
  logic          page_q;
  logic [PW-1:0] prescale;
  logic [1:0]    index;
  logic [TW-1:0] page_timer;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;

  logic [15:0]   shown;
  logic [3:0]    nib;
  logic          upper_zero;
  logic [6:0]    seg_next;

  function automatic logic [6:0] seven_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Segment pattern for the digit currently selected by the scan index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shown      = page_q ? r_held : q_held;
    nib        = shown[{index, 2'b00} +: 4];
    upper_zero = 1'b1;
    // A digit is blank only if it and every higher digit are zero; an invalid
    // nibble is nonzero and therefore keeps the digits below it visible.
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(index) && shown[j*4 +: 4] != 4'd0) upper_zero = 1'b0;
    end
    if (!valid_q)                       seg_next = SEG_DASH;
    else if (nib > 4'd9)                seg_next = SEG_E;
    else if (upper_zero && index != 0)  seg_next = SEG_BLANK;
    else                                seg_next = seven_seg(nib);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the capture registers are reset too, so no result survives a reset.
      q_held     <= '0;
      r_held     <= '0;
      valid_q    <= 1'b0;
      page_q     <= 1'b0;
      prescale   <= '0;
      index      <= '0;
      page_timer <= '0;
      an_q       <= 4'b1111;
      seg_q      <= SEG_BLANK;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      // Scan runs free, independent of whether a result is held.
      prescale <= (prescale == PRE_LAST) ? '0 : prescale + 1'b1;
      if (prescale == PRE_LAST) index <= index + 2'd1;

      // Capture has priority over clear.
      if (bus.end_division) begin
        q_held     <= bus.quotient;
        r_held     <= bus.remainder;
        valid_q    <= 1'b1;
        page_q     <= 1'b0;
        page_timer <= '0;
      end else if (bus.clear) begin
        valid_q    <= 1'b0;
        page_q     <= 1'b0;
        page_timer <= '0;
      end else if (valid_q) begin
        if (page_timer == PAGE_LAST) begin
          page_timer <= '0;
          page_q     <= ~page_q;
        end else begin
          page_timer <= page_timer + 1'b1;
        end
      end

      // Outputs are registered from the pre-edge index/page/data: one cycle of latency.
      an_q  <= ~(4'b0001 << index);
      seg_q <= seg_next;
    end
  end

  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.page  = page_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_bcd_result_display.sv
// Self-checking bench for bcd_result_display. A behavioural model derives the
// expected display from edge counts since reset/capture and from the held
// values with plain arithmetic; directed scenarios add constant checks.
module tb_bcd_result_display;
  localparam int SCAN_DIV    = 4;
  localparam int PAGE_CYCLES = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bcd_result_display_if bus ();

  bcd_result_display #(
    .SCAN_DIV    (SCAN_DIV),
    .PAGE_CYCLES (PAGE_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: edges since reset release, capture edge, held result.
  int          m_n;
  int          m_cap;
  bit          m_valid;
  logic [15:0] m_q;
  logic [15:0] m_r;

  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_page;
  logic       exp_valid;

  function automatic logic m_page();
    if (!m_valid) return 1'b0;
    return (((m_n - m_cap) / PAGE_CYCLES) % 2) == 1;
  endfunction

  function automatic logic [6:0] digit_pattern(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input bit valid, input logic [15:0] v, input int idx);
    int d;
    if (!valid) return 7'b0111111;
    d = int'((v >> (4 * idx)) & 16'h000F);
    if (d > 9) return 7'b0000110;
    if (idx > 0 && (v >> (4 * idx)) == 16'h0000) return 7'b1111111;
    return digit_pattern(d);
  endfunction

  // Advance one clock edge with the inputs currently on the bus, updating the
  // model expectations. Returns #1 after the rising edge.
  task automatic tick();
    int idx;
    idx     = (m_n / SCAN_DIV) % 4;
    exp_an  = ~(4'b0001 << idx);
    exp_seg = seg_of(m_valid, m_page() ? m_r : m_q, idx);
    if (bus.end_division) begin
      m_q = bus.quotient; m_r = bus.remainder; m_valid = 1'b1; m_cap = m_n + 1;
    end else if (bus.clear) begin
      m_valid = 1'b0;
    end
    m_n++;
    @(posedge clk); #1;
    exp_page  = m_page();
    exp_valid = m_valid;
  endtask

  task automatic model_reset();
    m_n = 0; m_cap = 0; m_valid = 1'b0; m_q = '0; m_r = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic pulse(input logic [15:0] q, input logic [15:0] r);
    bus.quotient = q; bus.remainder = r; bus.end_division = 1'b1;
    tick();
    bus.end_division = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] seq [4];
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.an, bus.seg, bus.page, bus.valid} !== {4'b1111, 7'b1111111, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got an=%b seg=%b page=%b valid=%b, want 1111 1111111 0 0",
               bus.an, bus.seg, bus.page, bus.valid);
    end
    release_reset();
    for (int t = 1; t <= 20; t++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg, bus.page, bus.valid} !== {exp_an, exp_seg, exp_page, exp_valid}) begin
        n_err++;
        $display("FAIL idle t=%0d: got an=%b seg=%b page=%b valid=%b, want an=%b seg=%b page=%b valid=%b",
                 t, bus.an, bus.seg, bus.page, bus.valid, exp_an, exp_seg, exp_page, exp_valid);
      end
      if (t % 4 == 1 && t <= 13) begin
        n_cmp++;
        if (bus.an !== seq[t / 4] || bus.seg !== 7'b0111111) begin
          n_err++;
          $display("FAIL idle_scan t=%0d: got an=%b seg=%b, want an=%b seg=0111111",
                   t, bus.an, bus.seg, seq[t / 4]);
        end
      end
    end
  endtask

  // Capture q/r, run through both pages and back, checking the model every
  // cycle plus constant digit patterns {d3,d2,d1,d0} inside each page window.
  task automatic run_pages(input string name, input logic [15:0] q, input logic [15:0] r,
                           input logic [27:0] p0, input logic [27:0] p1);
    logic [27:0] want_row;
    pulse(q, r);
    for (int t = 1; t <= 2 * PAGE_CYCLES + 8; t++) begin
      bus.quotient  = 16'($urandom);
      bus.remainder = 16'($urandom);
      tick();
      n_cmp++;
      if ({bus.an, bus.seg, bus.page, bus.valid} !== {exp_an, exp_seg, exp_page, exp_valid}) begin
        n_err++;
        $display("FAIL %s t=%0d: got an=%b seg=%b page=%b valid=%b, want an=%b seg=%b page=%b valid=%b",
                 name, t, bus.an, bus.seg, bus.page, bus.valid, exp_an, exp_seg, exp_page, exp_valid);
      end
      if (t == PAGE_CYCLES - 1 || t == PAGE_CYCLES || t == 2 * PAGE_CYCLES) begin
        n_cmp++;
        if (bus.page !== (t == PAGE_CYCLES)) begin
          n_err++;
          $display("FAIL %s_page_edge t=%0d: got page=%b, want %b", name, t, bus.page, t == PAGE_CYCLES);
        end
      end
      if ((t >= 2 && t <= PAGE_CYCLES - 2) || (t >= PAGE_CYCLES + 2 && t <= 2 * PAGE_CYCLES - 2)) begin
        want_row = (t < PAGE_CYCLES) ? p0 : p1;
        for (int i = 0; i < 4; i++) begin
          if (bus.an == ~(4'b0001 << i)) begin
            n_cmp++;
            if (bus.seg !== want_row[i*7 +: 7]) begin
              n_err++;
              $display("FAIL %s_digit%0d t=%0d: got seg=%b, want %b", name, i, t, bus.seg, want_row[i*7 +: 7]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_quotient_page();
    run_pages("q0042_r0005", 16'h0042, 16'h0005,
              {7'b1111111, 7'b1111111, 7'b0011001, 7'b0100100},
              {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010});
  endtask

  task automatic test_zero_and_inner_zero();
    run_pages("q0000_r1203", 16'h0000, 16'h1203,
              {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000},
              {7'b1111001, 7'b0100100, 7'b1000000, 7'b0110000});
  endtask

  task automatic test_invalid_nibble();
    run_pages("q00A1_r0B00", 16'h00A1, 16'h0B00,
              {7'b1111111, 7'b1111111, 7'b0000110, 7'b1111001},
              {7'b1111111, 7'b0000110, 7'b1000000, 7'b1000000});
  endtask

  task automatic test_clear();
    bus.quotient = 16'h0007; bus.remainder = 16'h0000;
    bus.end_division = 1'b1; bus.clear = 1'b1;
    tick();
    bus.end_division = 1'b0; bus.clear = 1'b0;
    n_cmp++;
    if (bus.valid !== 1'b1 || bus.page !== 1'b0) begin
      n_err++;
      $display("FAIL clear_vs_capture: got valid=%b page=%b, want 1 0", bus.valid, bus.page);
    end
    for (int t = 1; t <= 8; t++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg, bus.page, bus.valid} !== {exp_an, exp_seg, exp_page, exp_valid}) begin
        n_err++;
        $display("FAIL shown7 t=%0d: got an=%b seg=%b page=%b valid=%b, want an=%b seg=%b page=%b valid=%b",
                 t, bus.an, bus.seg, bus.page, bus.valid, exp_an, exp_seg, exp_page, exp_valid);
      end
      if (t >= 2 && bus.an == 4'b1110) begin
        n_cmp++;
        if (bus.seg !== 7'b1111000) begin
          n_err++;
          $display("FAIL shown7_digit0: got seg=%b, want 1111000", bus.seg);
        end
      end
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    n_cmp++;
    if (bus.valid !== 1'b0 || bus.page !== 1'b0) begin
      n_err++;
      $display("FAIL clear_alone: got valid=%b page=%b, want 0 0", bus.valid, bus.page);
    end
    for (int t = 1; t <= 8; t++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg, bus.page, bus.valid} !== {exp_an, 7'b0111111, 1'b0, 1'b0} ||
          bus.seg !== exp_seg) begin
        n_err++;
        $display("FAIL after_clear t=%0d: got an=%b seg=%b page=%b valid=%b, want an=%b seg=0111111 page=0 valid=0",
                 t, bus.an, bus.seg, bus.page, bus.valid, exp_an);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse(16'h0123, 16'h0456);
    repeat (PAGE_CYCLES + 6) tick();
    n_cmp++;
    if (bus.page !== 1'b1 || bus.valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_page: got page=%b valid=%b, want 1 1", bus.page, bus.valid);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.an, bus.seg, bus.page, bus.valid} !== {4'b1111, 7'b1111111, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got an=%b seg=%b page=%b valid=%b, want 1111 1111111 0 0",
               bus.an, bus.seg, bus.page, bus.valid);
    end
    @(posedge clk);
    release_reset();
    for (int t = 1; t <= 20; t++) begin
      tick();
      n_cmp++;
      if ({bus.an, bus.seg, bus.page, bus.valid} !== {exp_an, exp_seg, exp_page, exp_valid} ||
          bus.seg !== 7'b0111111) begin
        n_err++;
        $display("FAIL post_reset t=%0d: got an=%b seg=%b page=%b valid=%b, want an=%b seg=0111111 page=0 valid=0",
                 t, bus.an, bus.seg, bus.page, bus.valid, exp_an);
      end
    end
  endtask

  function automatic logic [15:0] rand_bcdish();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 1) v[i*4 +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic test_random();
    for (int k = 0; k < 15; k++) begin
      int len;
      bus.quotient  = rand_bcdish();
      bus.remainder = rand_bcdish();
      bus.end_division = 1'b1;
      bus.clear = ($urandom_range(0, 3) == 0);
      len = $urandom_range(10, 180);
      for (int t = 0; t < len; t++) begin
        tick();
        n_cmp++;
        if ({bus.an, bus.seg, bus.page, bus.valid} !== {exp_an, exp_seg, exp_page, exp_valid}) begin
          n_err++;
          $display("FAIL random k=%0d t=%0d: got an=%b seg=%b page=%b valid=%b, want an=%b seg=%b page=%b valid=%b",
                   k, t, bus.an, bus.seg, bus.page, bus.valid, exp_an, exp_seg, exp_page, exp_valid);
        end
        bus.end_division = 1'b0;
        bus.clear        = ($urandom_range(0, 99) == 0);
        bus.quotient     = 16'($urandom);
        bus.remainder    = 16'($urandom);
      end
      bus.clear = 1'b0;
    end
  endtask

  initial begin
    bus.end_division = 1'b0;
    bus.clear        = 1'b0;
    bus.quotient     = '0;
    bus.remainder    = '0;
    test_reset();
    test_quotient_page();
    test_zero_and_inner_zero();
    test_invalid_nibble();
    test_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
